led_mmio: RTL and testbench



---
 rtl/led_mmio_pkg.sv | 25 ++
 rtl/led_mmio_tick_gen.sv | 30 +++
 rtl/led_mmio.sv | 130 +++++++++++++
 tb/tb_led_mmio.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mmio_pkg.sv
// Shared register map and field positions for the memory-mapped LED counter.
package led_mmio_pkg;

  localparam logic [3:0] VALUE_OFS = 4'h0;
  localparam logic [3:0] CTRL_OFS  = 4'h4;
  localparam logic [3:0] PRESC_OFS = 4'h8;
  localparam logic [3:0] STAT_OFS  = 4'hC;

  localparam int EN_BIT   = 0;
  localparam int DIR_BIT  = 1;
  localparam int WRAP_BIT = 2;
  localparam int OVF_BIT  = 0;

  typedef enum logic [1:0] {
    REG_VALUE = VALUE_OFS[3:2],
    REG_CTRL  = CTRL_OFS[3:2],
    REG_PRESC = PRESC_OFS[3:2],
    REG_STAT  = STAT_OFS[3:2]
  } reg_sel_e;

  function automatic reg_sel_e word_to_sel(input logic [1:0] word_idx);
    return reg_sel_e'(word_idx);
  endfunction

endpackage

// File: rtl/led_mmio_tick_gen.sv
// Prescaler down-counter: one-cycle tick every reload+1 cycles while enabled.
module tick_gen #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               load,
  input  logic [PRESC_W-1:0] reload,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign tick = en && (r_cnt == '0);

  // A load always wins; while disabled the counter tracks the reload value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load || !en) begin
      r_cnt <= reload;
    end else if (r_cnt == '0) begin
      r_cnt <= reload;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/led_mmio.sv
// LED counter peripheral: 16-byte MMIO window with VALUE, CTRL, PRESCALE and
// STATUS registers plus prescaled up/down auto-count with wrap or saturate.
module led_mmio
  import led_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int          CNT_W     = 6,
  parameter int          PRESC_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [31:0]      a,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             hit,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   r_value;
  logic [2:0]         r_ctrl;
  logic [PRESC_W-1:0] r_presc;
  logic               r_ovf;

  logic               w_hit;
  reg_sel_e           w_sel;
  logic               w_wr;
  logic               w_wr_value;
  logic               w_wr_ctrl;
  logic               w_wr_presc;
  logic               w_wr_stat;
  logic               w_tick;
  logic [PRESC_W-1:0] w_reload;
  logic [CNT_W-1:0]   w_step_value;
  logic               w_at_bound;
  logic               w_unused;

  assign w_hit      = (a[31:4] == BASE_ADDR[31:4]);
  assign w_sel      = word_to_sel(a[3:2]);
  assign w_wr       = we && w_hit;
  assign w_wr_value = w_wr && (w_sel == REG_VALUE);
  assign w_wr_ctrl  = w_wr && (w_sel == REG_CTRL);
  assign w_wr_presc = w_wr && (w_sel == REG_PRESC);
  assign w_wr_stat  = w_wr && (w_sel == REG_STAT);
  assign w_unused   = ^{a[1:0], wd[31:PRESC_W]};

  // A PRESCALE write must restart the counter from the value being written.
  assign w_reload = w_wr_presc ? wd[PRESC_W-1:0] : r_presc;

  tick_gen #(
    .PRESC_W(PRESC_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (r_ctrl[EN_BIT]),
    .load  (w_wr_presc),
    .reload(w_reload),
    .tick  (w_tick)
  );

  always_comb begin
    w_step_value = r_value;
    w_at_bound   = 1'b0;
    if (r_ctrl[DIR_BIT]) begin
      if (r_value == '0) begin
        w_at_bound   = 1'b1;
        w_step_value = r_ctrl[WRAP_BIT] ? CNT_MAX : '0;
      end else begin
        w_step_value = r_value - 1'b1;
      end
    end else begin
      if (r_value == CNT_MAX) begin
        w_at_bound   = 1'b1;
        w_step_value = r_ctrl[WRAP_BIT] ? '0 : CNT_MAX;
      end else begin
        w_step_value = r_value + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
      r_ctrl  <= '0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_value) begin
        r_value <= wd[CNT_W-1:0];
      end else if (w_tick) begin
        r_value <= w_step_value;
      end

      if (w_wr_ctrl) begin
        r_ctrl <= wd[2:0];
      end

      if (w_wr_presc) begin
        r_presc <= wd[PRESC_W-1:0];
      end

      // A boundary step outranks a simultaneous W1C; a step discarded by a
      // VALUE write never flags overflow.
      if (w_tick && !w_wr_value && w_at_bound) begin
        r_ovf <= 1'b1;
      end else if (w_wr_stat && wd[OVF_BIT]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = '0;
    if (w_hit) begin
      case (w_sel)
        REG_VALUE: rd = {{(32-CNT_W){1'b0}}, r_value};
        REG_CTRL:  rd = {29'd0, r_ctrl};
        REG_PRESC: rd = {{(32-PRESC_W){1'b0}}, r_presc};
        REG_STAT:  rd = {31'd0, r_ovf};
        default:   rd = '0;
      endcase
    end
  end

  assign hit     = w_hit;
  assign cnt_out = r_value;

endmodule

// File: tb/tb_led_mmio.sv
// Scoreboard bench for led_mmio: expectations are queued with each stimulus
// step and drained against cnt_out / rd / hit after the following clock edge.
module tb_led_mmio;

  localparam logic [31:0] BASE   = 32'hFFFF0000;
  localparam logic [31:0] A_VAL  = BASE + 32'h0;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_PRE  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  localparam int K_CNT = 0;
  localparam int K_RD  = 1;
  localparam int K_HIT = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd;
  logic        hit;
  logic [5:0]  cnt_out;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  led_mmio #(
    .BASE_ADDR(BASE),
    .CNT_W    (6),
    .PRESC_W  (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .a      (a),
    .wd     (wd),
    .rd     (rd),
    .hit    (hit),
    .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_CNT: check("cnt_out", {26'd0, cnt_out}, e.exp);
        K_RD: begin
          a = e.addr;
          #1;
          check($sformatf("rd@%08h", e.addr), rd, e.exp);
        end
        default: begin
          a = e.addr;
          #1;
          check($sformatf("hit@%08h", e.addr), {31'd0, hit}, e.exp);
        end
      endcase
    end
    a = 32'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    a  = 32'h0;
    wd = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    push(K_CNT, 0, 0);
    push(K_RD, A_VAL, 0);
    push(K_RD, A_CTRL, 0);
    push(K_RD, A_PRE, 0);
    push(K_RD, A_STAT, 0);
    push(K_HIT, 32'h10010000, 0);
    drain();

    // Decode boundaries
    push(K_HIT, BASE, 1);
    push(K_HIT, BASE + 32'hF, 1);
    push(K_HIT, BASE + 32'h10, 0);
    push(K_HIT, BASE - 32'h4, 0);
    drain();

    // VALUE writes, ignored low address bits, out-of-window write
    bus_wr(A_VAL, 32'h2A);
    push(K_CNT, 0, 42);
    push(K_RD, A_VAL, 32'h2A);
    push(K_RD, BASE + 32'h3, 32'h2A);
    drain();
    bus_wr(A_VAL, 32'hFFFFFFC5);
    push(K_CNT, 0, 5);
    drain();
    bus_wr(32'h10010000, 32'h3F);
    push(K_CNT, 0, 5);
    push(K_RD, 32'h10010000, 0);
    drain();

    // CTRL/PRESCALE field widths (EN stays 0)
    bus_wr(A_CTRL, 32'hFFFFFFF6);
    push(K_RD, A_CTRL, 32'h6);
    drain();
    bus_wr(A_PRE, 32'hABCD1234);
    push(K_RD, A_PRE, 32'h1234);
    push(K_CNT, 0, 5);
    drain();

    // Prescaled up-count, R=3: first step 4 cycles after the CTRL edge
    bus_wr(A_PRE, 3);
    bus_wr(A_VAL, 0);
    bus_wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      push(K_CNT, 0, k / 4);
      cyc();
      drain();
    end
    bus_wr(A_CTRL, 0);
    cyc();
    cyc();
    cyc();
    cyc();
    push(K_CNT, 0, 3);
    push(K_RD, A_STAT, 0);
    drain();

    // Saturate up at 63, set-beats-clear, W1C, then wrap to 0
    bus_wr(A_PRE, 0);
    bus_wr(A_VAL, 62);
    bus_wr(A_CTRL, 32'h1);
    push(K_CNT, 0, 63);
    cyc();
    drain();
    push(K_CNT, 0, 63);
    cyc();
    drain();
    push(K_CNT, 0, 63);
    push(K_RD, A_STAT, 1);
    cyc();
    drain();
    bus_wr(A_STAT, 1);
    push(K_RD, A_STAT, 1);
    drain();
    bus_wr(A_CTRL, 0);
    bus_wr(A_STAT, 1);
    push(K_RD, A_STAT, 0);
    push(K_CNT, 0, 63);
    drain();
    bus_wr(A_CTRL, 32'h5);
    push(K_CNT, 0, 0);
    push(K_RD, A_STAT, 1);
    cyc();
    drain();
    bus_wr(A_CTRL, 0);
    push(K_CNT, 0, 1);
    drain();

    // Down, saturate at 0; VALUE write beats a same-cycle tick
    bus_wr(A_VAL, 0);
    bus_wr(A_STAT, 1);
    push(K_RD, A_STAT, 0);
    drain();
    bus_wr(A_CTRL, 32'h3);
    push(K_CNT, 0, 0);
    push(K_RD, A_STAT, 1);
    cyc();
    drain();
    push(K_CNT, 0, 0);
    cyc();
    drain();
    bus_wr(A_VAL, 10);
    push(K_CNT, 0, 10);
    drain();
    push(K_CNT, 0, 9);
    cyc();
    drain();
    push(K_CNT, 0, 8);
    cyc();
    drain();
    bus_wr(A_CTRL, 0);
    push(K_CNT, 0, 7);
    push(K_RD, A_CTRL, 0);
    drain();

    // Down with wrap: 0 -> 63
    bus_wr(A_VAL, 0);
    bus_wr(A_CTRL, 32'h7);
    push(K_CNT, 0, 63);
    cyc();
    drain();
    push(K_CNT, 0, 62);
    cyc();
    drain();
    bus_wr(A_CTRL, 0);
    push(K_CNT, 0, 61);
    drain();

    // Reset mid auto-count at 17 (R=1: a step every 2 cycles)
    bus_wr(A_PRE, 1);
    bus_wr(A_VAL, 15);
    bus_wr(A_CTRL, 32'h1);
    push(K_CNT, 0, 15);
    cyc();
    drain();
    push(K_CNT, 0, 16);
    cyc();
    drain();
    push(K_CNT, 0, 16);
    cyc();
    drain();
    push(K_CNT, 0, 17);
    cyc();
    drain();
    reset = 1'b1;
    push(K_CNT, 0, 0);
    cyc();
    drain();
    reset = 1'b0;
    cyc();
    cyc();
    cyc();
    push(K_CNT, 0, 0);
    push(K_RD, A_CTRL, 0);
    push(K_RD, A_PRE, 0);
    push(K_RD, A_STAT, 0);
    push(K_RD, A_VAL, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
